n64_poll_sequencer: RTL

- Owns the single-wire N64 controller line: drives the 0x01 poll command, then receives and deserialises the 32-bit status reply.
- Publishes latched buttons and joystick words with a one-cycle valid strobe.
- Sits between the board pad (open-drain) and the button-mapping logic, and decides when each poll frame starts.
- Replaces free-running capture with an explicit, timed, timeout-guarded transaction.

---
 rtl/n64_poll_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/n64_poll_sequencer.sv
// n64_poll_sequencer
// Owns the single-wire N64 controller line. It sends the 0x01 poll command, receives the
// 32-bit status reply, and publishes the buttons and stick words together with a one-cycle
// valid strobe. Every frame is timed and guarded by a timeout.
//
// Ports:
//   clock_i        system clock, all logic on the rising edge
//   reset_ni       asynchronous active-low reset
//   poll_req_i     single-cycle request to start a poll frame
//   auto_en_i      1 = start a frame by itself every AUTO_POLL_US
//   line_in_i      raw pad level (asynchronous)
//   line_oe_o      1 = pull the pad low, 0 = release it (external pull-up)
//   busy_o         a frame is in progress
//   valid_o        one-cycle pulse when a new status word has been latched
//   timeout_err_o  one-cycle pulse when a frame is aborted
//   buttons_o      button bits; the first received bit is buttons_o[15]
//   joy_x_o        signed stick X, first received bit is the MSB
//   joy_y_o        signed stick Y
module n64_poll_sequencer #(
    parameter int unsigned US_CYCLES    = 12,
    parameter int unsigned TIMEOUT_US   = 100,
    parameter int unsigned GAP_US       = 200,
    parameter int unsigned AUTO_POLL_US = 16667
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        poll_req_i,
    input  logic        auto_en_i,
    input  logic        line_in_i,
    output logic        line_oe_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic        timeout_err_o,
    output logic [15:0] buttons_o,
    output logic [7:0]  joy_x_o,
    output logic [7:0]  joy_y_o
);

    localparam int unsigned TickW      = $clog2(US_CYCLES + 1);
    localparam int unsigned UsW        = $clog2(TIMEOUT_US + 4);
    localparam int unsigned GapW       = $clog2(GAP_US + 1);
    localparam int unsigned AutoCycles = AUTO_POLL_US * US_CYCLES;
    localparam int unsigned AutoW      = $clog2(AutoCycles + 1);

    typedef enum logic [3:0] {
        StIdle, StTxLow, StTxHigh, StTxStop, StRxWait, StRxSample, StRxStop, StDone, StAbort
    } state_e;

    state_e             state_q, state_d;
    logic               sync1_q, sync2_q, prev_q;
    logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [UsW-1:0]     us_cnt_q, us_cnt_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [31:0]        sr_q, sr_d;
    logic               stop_seen_q, stop_seen_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [AutoW-1:0]   auto_q, auto_d;
    logic [15:0]        buttons_q, buttons_d;
    logic [7:0]         joy_x_q, joy_x_d, joy_y_q, joy_y_d;

    logic               tick, fall, timeout_hit, gap_done, auto_exp, start_req;
    logic               phase_restart, restart;
    logic [UsW-1:0]     low_last, high_last;

    assign tick        = (tick_cnt_q == TickW'(US_CYCLES - 1));
    // Edge detect runs on the synchronised line; only RX states look at it, so our own
    // transmitted edges never count as reply bits.
    assign fall        = prev_q & ~sync2_q;
    assign timeout_hit = tick && (us_cnt_q == UsW'(TIMEOUT_US - 1));
    // The last microsecond of the gap finishes on this tick, so a request here is accepted.
    assign gap_done    = (gap_q == '0) || ((gap_q == GapW'(1)) && tick);
    assign auto_exp    = auto_en_i && (auto_q == AutoW'(AutoCycles - 1));
    assign start_req   = poll_req_i | auto_exp;
    // The command is 0x01 sent MSB first: only bit index 7 is a '1'.
    assign low_last    = (bit_cnt_q == 5'd7) ? UsW'(0) : UsW'(2);
    assign high_last   = (bit_cnt_q == 5'd7) ? UsW'(2) : UsW'(0);

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        sr_d          = sr_q;
        stop_seen_d   = stop_seen_q;
        buttons_d     = buttons_q;
        joy_x_d       = joy_x_q;
        joy_y_d       = joy_y_q;
        gap_d         = gap_q;
        phase_restart = 1'b0;
        line_oe_o     = 1'b0;
        valid_o       = 1'b0;
        timeout_err_o = 1'b0;

        if (tick && (gap_q != '0)) gap_d = gap_q - GapW'(1);

        auto_d = '0;
        if (auto_en_i && !auto_exp) auto_d = auto_q + AutoW'(1);

        unique case (state_q)
            StIdle: begin
                if (start_req && gap_done) begin
                    state_d   = StTxLow;
                    bit_cnt_d = '0;
                end
            end
            StTxLow: begin
                line_oe_o = 1'b1;
                if (tick && (us_cnt_q == low_last)) state_d = StTxHigh;
            end
            StTxHigh: begin
                if (tick && (us_cnt_q == high_last)) begin
                    if (bit_cnt_q == 5'd7) begin
                        state_d = StTxStop;
                    end else begin
                        state_d   = StTxLow;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            StTxStop: begin
                line_oe_o = 1'b1;
                if (tick) begin
                    state_d     = StRxWait;
                    bit_cnt_d   = '0;
                    stop_seen_d = 1'b0;
                end
            end
            StRxWait: begin
                if (fall) state_d = StRxSample;
                else if (timeout_hit) state_d = StAbort;
            end
            StRxSample: begin
                if (tick && (us_cnt_q == UsW'(1))) begin
                    sr_d      = {sr_q[30:0], sync2_q};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    state_d   = (bit_cnt_q == 5'd31) ? StRxStop : StRxWait;
                end
            end
            StRxStop: begin
                // Two phases: wait for the stop-bit edge, then let 2 us pass before finishing.
                if (!stop_seen_q) begin
                    if (fall) begin
                        stop_seen_d   = 1'b1;
                        phase_restart = 1'b1;
                    end else if (timeout_hit) begin
                        state_d = StAbort;
                    end
                end else if (tick && (us_cnt_q == UsW'(1))) begin
                    state_d   = StDone;
                    buttons_d = sr_q[31:16];
                    joy_x_d   = sr_q[15:8];
                    joy_y_d   = sr_q[7:0];
                end
            end
            StDone: begin
                valid_o = 1'b1;
                gap_d   = GapW'(GAP_US);
                state_d = StIdle;
            end
            StAbort: begin
                timeout_err_o = 1'b1;
                gap_d         = GapW'(GAP_US);
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Restarting the timebase on every phase change keeps phase lengths exact.
        restart    = (state_d != state_q) || phase_restart;
        tick_cnt_d = (restart || tick) ? '0 : tick_cnt_q + TickW'(1);
        us_cnt_d   = restart ? '0 : (tick ? us_cnt_q + UsW'(1) : us_cnt_q);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            tick_cnt_q  <= '0;
            us_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            stop_seen_q <= 1'b0;
            gap_q       <= '0;
            auto_q      <= '0;
            buttons_q   <= '0;
            joy_x_q     <= '0;
            joy_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= line_in_i;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            tick_cnt_q  <= tick_cnt_d;
            us_cnt_q    <= us_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            stop_seen_q <= stop_seen_d;
            gap_q       <= gap_d;
            auto_q      <= auto_d;
            buttons_q   <= buttons_d;
            joy_x_q     <= joy_x_d;
            joy_y_q     <= joy_y_d;
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign buttons_o = buttons_q;
    assign joy_x_o   = joy_x_q;
    assign joy_y_o   = joy_y_q;

endmodule
